// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined left shifter/rotator.
package shifter_pkg;

   typedef enum logic {
      SHL_LOGIC = 1'b0,
      SHL_ROT   = 1'b1
   } shift_mode_e;

   function automatic int shw(int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/shl_stage.sv
// One mux level of the left shifter: optional shift/rotate by SH, then a register.
module shl_stage
   import shifter_pkg::*;
#(
   parameter int N  = 8,
   parameter int SH = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          vld_i,
   input  logic [N-1:0]  d_i,
   input  logic          sel,
   input  shift_mode_e   mode_i,
   output logic          vld_o,
   output logic [N-1:0]  d_o,
   output shift_mode_e   mode_o
);

   logic          vld_d, vld_q;
   logic [N-1:0]  data_d, data_q;
   shift_mode_e   mode_d, mode_q;
   logic [N-1:0]  shifted;

   always_comb begin
      shifted = d_i;
      if (sel) begin
         if (mode_i == SHL_ROT) shifted = {d_i[N-1-SH:0], d_i[N-1:N-SH]};
         else                   shifted = {d_i[N-1-SH:0], {SH{1'b0}}};
      end
   end

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      mode_d = mode_q;
      if (en) begin
         vld_d  = vld_i;
         data_d = shifted;
         mode_d = mode_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         data_q <= '0;
         mode_q <= SHL_LOGIC;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
         mode_q <= mode_d;
      end
   end

   assign vld_o  = vld_q;
   assign d_o    = data_q;
   assign mode_o = mode_q;

endmodule

// File: rtl/barrel_shiftl_pipe.sv
// Pipelined logarithmic left shifter/rotator, one register per mux level,
// with a single global advance so the whole pipe moves or holds together.
module barrel_shiftl_pipe
   import shifter_pkg::*;
#(
   parameter int N    = 8,
   parameter int ITER = shw(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic [ITER-1:0]  in_sh_amt,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_data,
   output logic [ITER-1:0]  stage_vld
);

   logic             advance;
   logic             vld_s  [ITER];
   logic [N-1:0]     d_s    [ITER];
   shift_mode_e      mode_s [ITER];
   logic [ITER-1:0]  amt_d  [ITER];
   logic [ITER-1:0]  amt_q  [ITER];

   // Bubbles are kept in place; only a valid beat in the last stage can stall.
   assign advance   = !vld_s[ITER-1] || out_ready;
   assign in_ready  = advance;
   assign out_valid = vld_s[ITER-1];
   assign out_data  = d_s[ITER-1];

   always_comb begin
      for (int i = 0; i < ITER; i++) amt_d[i] = amt_q[i];
      if (advance) begin
         amt_d[0] = in_sh_amt;
         for (int i = 1; i < ITER; i++) amt_d[i] = amt_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ITER; i++) amt_q[i] <= '0;
      end else begin
         for (int i = 0; i < ITER; i++) amt_q[i] <= amt_d[i];
      end
   end

   for (genvar i = 0; i < ITER; i++) begin : g_stage
      logic          vld_in;
      logic [N-1:0]  d_in;
      shift_mode_e   mode_in;
      logic          sel;

      if (i == 0) begin : g_first
         assign vld_in  = in_valid;
         assign d_in    = in_data;
         assign mode_in = shift_mode_e'(in_mode);
         assign sel     = in_sh_amt[0];
      end else begin : g_next
         assign vld_in  = vld_s[i-1];
         assign d_in    = d_s[i-1];
         assign mode_in = mode_s[i-1];
         assign sel     = amt_q[i-1][i];
      end

      shl_stage #(
         .N  (N),
         .SH (2**i)
      ) u_stage (
         .clk    (clk),
         .rst_n  (rst_n),
         .en     (advance),
         .vld_i  (vld_in),
         .d_i    (d_in),
         .sel    (sel),
         .mode_i (mode_in),
         .vld_o  (vld_s[i]),
         .d_o    (d_s[i]),
         .mode_o (mode_s[i])
      );

      assign stage_vld[i] = vld_s[i];
   end

endmodule

// File: tb/tb_barrel_shiftl_pipe.sv
// Directed bench for barrel_shiftl_pipe (N=8) with a negedge scoreboard on every beat.
module tb_barrel_shiftl_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic [2:0]  in_sh_amt = '0;
   logic        in_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [2:0]  stage_vld;

   int vec_cnt = 0;
   int err_cnt = 0;
   logic [7:0] sb_q [$];
   logic [7:0] sb_exp;

   barrel_shiftl_pipe #(.N(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sh_amt (in_sh_amt),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .stage_vld (stage_vld)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s, input logic m);
      logic [15:0] t;
      t = {d, d} << s;
      if (m) return t[15:8];
      return d << s;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            vec_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_underflow: got %h with no beat outstanding", out_data);
               err_cnt++;
            end else begin
               sb_exp = sb_q.pop_front();
               if (out_data !== sb_exp) begin
                  $display("FAIL sb_data: got %h expected %h", out_data, sb_exp);
                  err_cnt++;
               end
            end
         end
         if (in_valid && in_ready) sb_q.push_back(model(in_data, in_sh_amt, in_mode));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      vec_cnt++;
      if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); err_cnt++; end
      vec_cnt++;
      if (out_data !== 8'h00) begin $display("FAIL reset_out_data: got %h expected 00", out_data); err_cnt++; end
      vec_cnt++;
      if (stage_vld !== 3'b000) begin $display("FAIL reset_stage_vld: got %b expected 000", stage_vld); err_cnt++; end
      rst_n = 1'b1;
      #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); err_cnt++; end
      tick();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 8'b0000_0001; in_sh_amt = 3'd3; in_mode = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) tick();
         vec_cnt++;
         if (out_valid !== (c == 3)) begin
            $display("FAIL single_latency c=%0d: out_valid got %b expected %b", c, out_valid, (c == 3));
            err_cnt++;
         end
         if (c == 3) begin
            vec_cnt++;
            if (out_data !== 8'b0000_1000) begin $display("FAIL single_data: got %h expected 08", out_data); err_cnt++; end
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [7] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
      in_mode = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         if (cyc < 7) begin
            in_valid = 1'b1; in_data = 8'hFF; in_sh_amt = 3'(cyc + 1);
            #1;
            vec_cnt++;
            if (in_ready !== 1'b1) begin $display("FAIL b2b_in_ready cyc=%0d: got %b expected 1", cyc, in_ready); err_cnt++; end
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (cyc >= 2 && cyc <= 8) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_b[cyc-2]) begin
               $display("FAIL b2b_out cyc=%0d: got v=%b d=%h expected v=1 d=%h", cyc, out_valid, out_data, exp_b[cyc-2]);
               err_cnt++;
            end
         end
      end
      tick();
   endtask

   task automatic test_rotate();
      logic [7:0] din [3] = '{8'h81, 8'hA5, 8'h01};
      logic [2:0] sh  [3] = '{3'd1, 3'd4, 3'd7};
      logic [7:0] exp_r [3] = '{8'h03, 8'h5A, 8'h80};
      in_mode = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc < 3) begin
            in_valid = 1'b1; in_data = din[cyc]; in_sh_amt = sh[cyc];
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (cyc >= 2 && cyc <= 4) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_data !== exp_r[cyc-2]) begin
               $display("FAIL rot_out cyc=%0d: got v=%b d=%h expected v=1 d=%h", cyc, out_valid, out_data, exp_r[cyc-2]);
               err_cnt++;
            end
         end
      end
      in_mode = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      logic [7:0] exp_s [3] = '{8'h02, 8'h04, 8'h08};
      out_ready = 1'b0;
      in_mode = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         in_valid = 1'b1; in_data = 8'h01; in_sh_amt = 3'(cyc);
         tick();
      end
      in_valid = 1'b1; in_data = 8'h01; in_sh_amt = 3'd3;
      for (int k = 0; k < 5; k++) begin
         #1;
         vec_cnt++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h01 || stage_vld !== 3'b111) begin
            $display("FAIL stall_hold k=%0d: got rdy=%b v=%b d=%h sv=%b expected rdy=0 v=1 d=01 sv=111",
                     k, in_ready, out_valid, out_data, stage_vld);
            err_cnt++;
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      vec_cnt++;
      if (in_ready !== 1'b1) begin $display("FAIL stall_release_ready: got %b expected 1", in_ready); err_cnt++; end
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vec_cnt++;
         if (out_valid !== 1'b1 || out_data !== exp_s[k]) begin
            $display("FAIL stall_drain k=%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid, out_data, exp_s[k]);
            err_cnt++;
         end
         tick();
      end
      vec_cnt++;
      if (out_valid !== 1'b0) begin $display("FAIL stall_empty: got v=%b expected 0", out_valid); err_cnt++; end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [7:0] din [3] = '{8'h11, 8'h22, 8'h33};
      in_mode = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         in_valid = 1'b1; in_data = din[cyc]; in_sh_amt = 3'(cyc + 1);
         tick();
      end
      in_valid = 1'b0;
      vec_cnt++;
      if (stage_vld !== 3'b111) begin $display("FAIL rstmid_full: got sv=%b expected 111", stage_vld); err_cnt++; end
      #2;
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || stage_vld !== 3'b000) begin
         $display("FAIL rstmid_async: got v=%b d=%h sv=%b expected v=0 d=00 sv=000", out_valid, out_data, stage_vld);
         err_cnt++;
      end
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_data = 8'h03; in_sh_amt = 3'd2;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      vec_cnt++;
      if (out_valid !== 1'b1 || out_data !== 8'h0C) begin
         $display("FAIL rstmid_after: got v=%b d=%h expected v=1 d=0c", out_valid, out_data);
         err_cnt++;
      end
      tick();
   endtask

   task automatic test_bubbles();
      logic       pat   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [7:0] din   [5] = '{8'h3C, 8'h00, 8'h5A, 8'h00, 8'hC3};
      logic [2:0] exp_sv [7] = '{3'b001, 3'b010, 3'b101, 3'b010, 3'b101, 3'b010, 3'b100};
      logic [7:0] exp_d  [7] = '{8'h00, 8'h00, 8'h3C, 8'h00, 8'h5A, 8'h00, 8'hC3};
      in_mode = 1'b0;
      in_sh_amt = 3'd0;
      for (int cyc = 0; cyc < 7; cyc++) begin
         if (cyc < 5) begin
            in_valid = pat[cyc]; in_data = din[cyc];
         end else begin
            in_valid = 1'b0;
         end
         tick();
         vec_cnt++;
         if (stage_vld !== exp_sv[cyc]) begin
            $display("FAIL bubble_sv cyc=%0d: got %b expected %b", cyc, stage_vld, exp_sv[cyc]);
            err_cnt++;
         end
         if (exp_sv[cyc][2]) begin
            vec_cnt++;
            if (out_data !== exp_d[cyc]) begin
               $display("FAIL bubble_data cyc=%0d: got %h expected %h", cyc, out_data, exp_d[cyc]);
               err_cnt++;
            end
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_rotate();
      test_stall();
      test_reset_mid();
      test_bubbles();
      tick();
      vec_cnt++;
      if (sb_q.size() != 0) begin
         $display("FAIL sb_leftover: got %0d beats outstanding expected 0", sb_q.size());
         err_cnt++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
